// File: rtl/bcd_stopwatch_pkg.sv
// Shared constants and types for the BCD stopwatch.
// Used by the RTL and by its bench.
package bcd_stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  localparam int TICK_DIV_DEF = 100000;

  typedef struct packed {
    logic s1;
    logic s2;
    logic hist;
    logic arm;
  } btn_sync_t;

endpackage

// File: rtl/bcd_stopwatch_digit.sv
// One decimal digit of the stopwatch count.
// Carry is combinational so a whole chain rolls on one edge.
module bcd_digit
  import bcd_stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  assign carry = inc && (q == BCD_MAX);

  // digit register: clear wins, 9 rolls to 0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (carry)
      q <= '0;
    else if (inc)
      q <= q + 4'd1;
  end

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch with start/stop and clear buttons.
// Buttons are synchronised and edge detected inside.
module bcd_stopwatch
  import bcd_stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_clr,
  output logic [3:0] d0,
  output logic [3:0] d1,
  output logic [3:0] d2,
  output logic [3:0] d3,
  output logic       running,
  output logic       wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TD_MAX =
    PW'(TICK_DIV - 1);

  logic [1:0]    warm;
  btn_sync_t     ss_q;
  btn_sync_t     clr_q;
  logic          ss_p;
  logic          clr_p;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [PW-1:0] presc;
  logic          tick;
  logic          c0;
  logic          c1;
  logic          c2;
  logic          c3;

  // marks when the second sync flop holds a real sample
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      warm <= '0;
    else
      warm <= {warm[0], 1'b1};
  end

  // start/stop sync, history and release arming
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ss_q <= '0;
    end else begin
      ss_q.s1   <= btn_ss;
      ss_q.s2   <= ss_q.s1;
      ss_q.hist <= ss_q.s2;
      ss_q.arm  <= ss_q.arm | (warm[1] & ~ss_q.s2);
    end
  end

  // clear sync, history and release arming
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_q <= '0;
    end else begin
      clr_q.s1   <= btn_clr;
      clr_q.s2   <= clr_q.s1;
      clr_q.hist <= clr_q.s2;
      clr_q.arm  <= clr_q.arm | (warm[1] & ~clr_q.s2);
    end
  end

  assign ss_p  = ss_q.arm & ss_q.s2 & ~ss_q.hist;
  assign clr_p = clr_q.arm & clr_q.s2 & ~clr_q.hist;

  // next state: clear beats start/stop
  always_comb begin
    state_nx = state;
    if (clr_p) begin
      state_nx = ST_IDLE;
    end else if (ss_p) begin
      unique case (state)
        ST_IDLE:  state_nx = ST_RUN;
        ST_RUN:   state_nx = ST_PAUSE;
        ST_PAUSE: state_nx = ST_RUN;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  // state and its registered run decode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == ST_RUN);
    end
  end

  // prescaler runs in RUN only, holds in PAUSE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      presc <= '0;
    else if (clr_p)
      presc <= '0;
    else if (state == ST_RUN)
      presc <= (presc == TD_MAX) ? '0
             : presc + PW'(1);
  end

  assign tick = (state == ST_RUN) && (presc == TD_MAX);

  bcd_digit u_d0 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_p),
    .inc   (tick),
    .q     (d0),
    .carry (c0)
  );

  bcd_digit u_d1 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_p),
    .inc   (c0),
    .q     (d1),
    .carry (c1)
  );

  bcd_digit u_d2 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_p),
    .inc   (c1),
    .q     (d2),
    .carry (c2)
  );

  bcd_digit u_d3 (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr_p),
    .inc   (c2),
    .q     (d3),
    .carry (c3)
  );

  // one-cycle pulse on the 9999 -> 0000 roll
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      wrap <= 1'b0;
    else
      wrap <= c3 & ~clr_p;
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch with a run-time reference
// model kept as total RUN cycles since the last clear.
module tb_bcd_stopwatch;
  import bcd_stopwatch_pkg::*;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_ss = 1'b0;
  logic btn_clr = 1'b0;
  logic [3:0] d0, d1, d2, d3;
  logic running, wrap;
  logic [15:0] dig;

  int vectors = 0;
  int miscompares = 0;

  bcd_stopwatch #(.TICK_DIV(TD)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .d0      (d0),
    .d1      (d1),
    .d2      (d2),
    .d3      (d3),
    .running (running),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  assign dig = {d3, d2, d1, d0};

  // reference model
  logic [1:0] m_state = ST_IDLE;
  int m_ticks = 0;
  bit m_wrap = 0;
  int m_n = 0;
  bit ss_h[3];
  bit clr_h[3];
  bit ss_e, clr_e;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_state = ST_IDLE;
      m_ticks = 0;
      m_wrap  = 0;
      m_n     = 0;
      ss_h    = '{0, 0, 0};
      clr_h   = '{0, 0, 0};
    end else begin
      ss_e  = (m_n >= 3) && ss_h[1] && !ss_h[2];
      clr_e = (m_n >= 3) && clr_h[1] && !clr_h[2];
      ss_h[2]  = ss_h[1];
      ss_h[1]  = ss_h[0];
      ss_h[0]  = btn_ss;
      clr_h[2] = clr_h[1];
      clr_h[1] = clr_h[0];
      clr_h[0] = btn_clr;
      if (m_n < 3) m_n++;
      m_wrap = 0;
      if (clr_e) begin
        m_state = ST_IDLE;
        m_ticks = 0;
      end else begin
        if (m_state == ST_RUN) begin
          m_ticks++;
          if (m_ticks % TD == 0 &&
              (m_ticks / TD) % 10000 == 0)
            m_wrap = 1;
        end
        if (ss_e)
          m_state = (m_state == ST_RUN) ?
                    ST_PAUSE : ST_RUN;
      end
    end
  end

  function automatic logic [15:0] exp_bcd();
    int v;
    v = (m_ticks / TD) % 10000;
    return {4'(v / 1000), 4'((v / 100) % 10),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // one-cycle button press, caller sits just after a negedge
  task automatic press(input bit ss, input bit cl);
    btn_ss  = ss;
    btn_clr = cl;
    @(negedge clk);
    btn_ss  = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic do_clr();
    press(1'b0, 1'b1);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (dig !== 16'h0000)
      $display("FAIL reset_digits: got %h want 0000", dig);
    vectors++;
    if ({running, wrap} !== 2'b00)
      $display("FAIL reset_flags: got %b want 00",
               {running, wrap});
    if (dig !== 16'h0000 || {running, wrap} !== 2'b00)
      miscompares++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (running !== 1'b0 || dig !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_release: run %b dig %h want 0 0000",
               running, dig);
    end
  endtask

  task automatic test_start();
    press(1'b1, 1'b0);
    @(negedge clk);
    vectors++;
    if (running !== 1'b0) begin
      miscompares++;
      $display("FAIL start_early: running %b want 0", running);
    end
    @(negedge clk);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_third_edge: running %b want 1",
               running);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (dig !== 16'h0000) begin
      miscompares++;
      $display("FAIL first_tick_early: got %h want 0000", dig);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 16'h0001) begin
      miscompares++;
      $display("FAIL first_tick: got %h want 0001", dig);
    end
    repeat (4) @(negedge clk);
    vectors++;
    if (dig !== 16'h0002 || dig !== exp_bcd()) begin
      miscompares++;
      $display("FAIL second_tick: got %h want 0002 model %h",
               dig, exp_bcd());
    end
  endtask

  task automatic test_pause_resume();
    do_clr();
    press(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    repeat (7) @(negedge clk);
    press(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (running !== 1'b0 || dig !== 16'h0002) begin
      miscompares++;
      $display("FAIL pause_entry: run %b dig %h want 0 0002",
               running, dig);
    end
    repeat (20) @(negedge clk);
    vectors++;
    if (running !== 1'b0 || dig !== 16'h0002) begin
      miscompares++;
      $display("FAIL pause_hold: run %b dig %h want 0 0002",
               running, dig);
    end
    press(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (running !== 1'b1 || dig !== 16'h0002) begin
      miscompares++;
      $display("FAIL resume: run %b dig %h want 1 0002",
               running, dig);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 16'h0002) begin
      miscompares++;
      $display("FAIL resume_early: got %h want 0002", dig);
    end
    @(negedge clk);
    vectors++;
    if (dig !== 16'h0003 || dig !== exp_bcd()) begin
      miscompares++;
      $display("FAIL resume_partial: got %h want 0003", dig);
    end
  endtask

  task automatic test_clr_priority();
    int n;
    do_clr();
    press(1'b1, 1'b0);
    n = 0;
    while (dig !== 16'h0042 && n < 400) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dig !== 16'h0042) begin
      miscompares++;
      $display("FAIL reach_0042: got %h want 0042", dig);
    end
    press(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    vectors++;
    if (running !== 1'b0 || dig !== 16'h0042) begin
      miscompares++;
      $display("FAIL pause_0042: run %b dig %h want 0 0042",
               running, dig);
    end
    press(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    vectors++;
    if (running !== 1'b0 || dig !== 16'h0000) begin
      miscompares++;
      $display("FAIL clr_priority: run %b dig %h want 0 0000",
               running, dig);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (running !== 1'b0 || dig !== exp_bcd() ||
        dig !== 16'h0000) begin
      miscompares++;
      $display("FAIL clr_stays_idle: run %b dig %h want 0 0000",
               running, dig);
    end
  endtask

  task automatic test_carry();
    int n;
    do_clr();
    press(1'b1, 1'b0);
    n = 0;
    while (dig !== 16'h0999 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dig !== 16'h0999) begin
      miscompares++;
      $display("FAIL reach_0999: got %h want 0999", dig);
    end
    n = 0;
    while (dig === 16'h0999 && n < 8) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dig !== 16'h1000 || dig !== exp_bcd()) begin
      miscompares++;
      $display("FAIL ripple_1000: got %h want 1000", dig);
    end
    n = 0;
    while (dig !== 16'h9999 && n < 40000) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dig !== 16'h9999 || wrap !== 1'b0) begin
      miscompares++;
      $display("FAIL reach_9999: dig %h wrap %b want 9999 0",
               dig, wrap);
    end
    n = 0;
    while (dig === 16'h9999 && n < 8) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (dig !== 16'h0000 || wrap !== 1'b1) begin
      miscompares++;
      $display("FAIL rollover: dig %h wrap %b want 0000 1",
               dig, wrap);
    end
    @(negedge clk);
    vectors++;
    if (wrap !== 1'b0 || running !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_width: wrap %b run %b want 0 1",
               wrap, running);
    end
    repeat (TD) @(negedge clk);
    vectors++;
    if (dig !== 16'h0001 || dig !== exp_bcd()) begin
      miscompares++;
      $display("FAIL count_after_wrap: got %h want 0001", dig);
    end
  endtask

  task automatic test_hold();
    int rises;
    logic prev;
    do_clr();
    rises = 0;
    prev = running;
    btn_ss = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (running && !prev) rises++;
      prev = running;
    end
    btn_ss = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (running && !prev) rises++;
      prev = running;
    end
    vectors++;
    if (rises !== 1 || running !== 1'b1 ||
        (m_state == ST_RUN) !== running) begin
      miscompares++;
      $display("FAIL hold_single: rises %0d run %b want 1 1",
               rises, running);
    end
  endtask

  task automatic test_reset_midrun();
    int held_bad;
    do_clr();
    press(1'b1, 1'b0);
    repeat (11) @(negedge clk);
    vectors++;
    if (running !== 1'b1 || dig === 16'h0000) begin
      miscompares++;
      $display("FAIL midrun_pre: run %b dig %h want 1 nonzero",
               running, dig);
    end
    #2 rst = 1'b0;
    #1;
    vectors++;
    if ({running, wrap, dig} !== 18'h0) begin
      miscompares++;
      $display("FAIL async_reset: run %b wrap %b dig %h want 0",
               running, wrap, dig);
    end
    btn_ss = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    held_bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (running !== 1'b0 || dig !== 16'h0000) held_bad++;
    end
    vectors++;
    if (held_bad != 0) begin
      miscompares++;
      $display("FAIL held_through_release: %0d bad cycles want 0",
               held_bad);
    end
    btn_ss = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (running !== 1'b0 || dig !== exp_bcd()) begin
      miscompares++;
      $display("FAIL after_release: run %b dig %h want 0 %h",
               running, dig, exp_bcd());
    end
    press(1'b1, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (running !== 1'b1) begin
      miscompares++;
      $display("FAIL start_after_reset: run %b want 1", running);
    end
  endtask

  task automatic test_random();
    logic [17:0] exp;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) btn_ss = ~btn_ss;
      if ($urandom_range(0, 63) == 0) btn_clr = ~btn_clr;
      @(negedge clk);
      exp = {(m_state == ST_RUN), m_wrap, exp_bcd()};
      vectors++;
      if ({running, wrap, dig} !== exp) begin
        miscompares++;
        $display("FAIL random_cycle %0d: got %h want %h",
                 i, {running, wrap, dig}, exp);
      end
    end
    btn_ss = 1'b0;
    btn_clr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_start();
    test_pause_resume();
    test_clr_priority();
    test_carry();
    test_hold();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
